y86_mem_arbiter: RTL
====================

Y86_MEM_ARBITER -- requirements
Module: y86_mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, read latency in cycles from mem_RE to valid mem_in (legal 1..4).
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  request from port 0 (CPU) and port 1 (DMA/debug); held high until the matching done.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; sampled with req.
REQ-007 addr0, addr1  input  AW each  word address; sampled with req.
REQ-008 wdata0, wdata1  input  32 each  write data; sampled with req.
REQ-009 gnt0, gnt1  output  1 each  port owns the memory bus this transaction.
REQ-010 done0, done1  output  1 each  one-cycle pulse; transaction complete.
REQ-011 rdata  output  32  read data; valid in the done cycle of a read.
REQ-012 mem_A  output  AW  memory address.
REQ-013 mem_RE, mem_WE  output  1 each  memory read / write strobe.
REQ-014 mem_out  output  32  memory write data.
REQ-015 mem_in  input  32  memory read data.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: with any req high, choose a winner, latch its we/addr/wdata, assert its gnt from the next cycle, and go to ISSUE.
REQ-018 Arbitration: round-robin. Pointer last = port of the most recent grant. When both ports request, the port other than last wins. A single requester always wins.
REQ-019 ISSUE lasts exactly 1 cycle.
  - mem_A = latched address.
  - Write: mem_WE = 1, mem_out = latched wdata, next state DONE.
  - Read: mem_RE = 1, next state WAIT; the wait counter is loaded with RD_LAT-1.
REQ-020 WAIT: counter decrements each cycle. When the counter is 0, capture mem_in into rdata and go to DONE. With RD_LAT = 1, WAIT lasts 1 cycle.
REQ-021 DONE: the granted port's done pulses 1 cycle, gnt drops, and the next state is IDLE.
  - Write latency: req to done = 3 cycles (IDLE, ISSUE, DONE).
  - Read latency: req to done = 3 + RD_LAT cycles.
REQ-022 mem_RE and mem_WE are 1 only in ISSUE, never together.
  - mem_A and mem_out are 0 outside ISSUE.
REQ-023 gnt0 and gnt1 are mutually exclusive at all times.
  - Exactly one gnt is high from ISSUE through DONE.
REQ-024 rdata holds its last captured value until the next read capture. Writes do not change rdata.
REQ-025 A req that drops mid-transaction does not abort it: the transaction completes and done still pulses.
REQ-026 A req still high in the DONE cycle counts as a new request in the following IDLE. No back-to-back grant occurs without passing through IDLE.
REQ-027 Simultaneous req0 and req1 arriving in IDLE resolve per REQ-018 in the same cycle.

Reset
REQ-028 Reset, asynchronous while rst = 0, forces:
  - state IDLE, last = 1 (so port 0 wins the first contention);
  - counter 0, rdata 0;
  - all gnt, done, mem_RE and mem_WE at 0; mem_A and mem_out at 0.
REQ-029 Reset mid-transaction abandons it with no done pulse. Operation resumes from IDLE on the first clk edge after rst returns high.

Configuration
REQ-030 Macro Y86_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, port 0 always wins contention; the last pointer is not implemented.
  - Undefined: round-robin per REQ-018.

Structure
REQ-031 Shared package y86_mem_pkg holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/DONE);
  - the port-index type;
  - constants RD_LAT_MAX = 4 and DATA_W = 32.
REQ-032 One sub-module, y86_rr_pick: combinational 2-way round-robin picker with inputs req[1:0] and last, output winner. Under Y86_ARB_FIXED_PRIO_EN it reduces to "port 0 if req0".

Verification
REQ-033 Single write: req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF -> one cycle with mem_WE = 1, mem_A = 0x10, mem_out = 0xDEADBEEF; done0 pulses 3 cycles after req0.
REQ-034 Read, RD_LAT = 3: req1 read at addr 0x20, memory returns 0x12345678 -> rdata = 0x12345678 with done1 at cycle 6; gnt0 stays 0 throughout.
REQ-035 Contention, both req held high for 4 transactions from reset -> grant order 0,1,0,1; with Y86_ARB_FIXED_PRIO_EN defined -> order 0,0,0,0.
REQ-036 req0 read with req0 dropped during WAIT -> transaction completes; done0 pulses once; no new grant follows.
REQ-037 rst driven low during WAIT of a port-1 read -> gnt1, mem_RE and rdata are 0 immediately; no done1 pulse; the next req0 after reset is granted normally.
REQ-038 Every cycle of every test: assert gnt0 & gnt1 == 0 and mem_RE & mem_WE == 0.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared types and constants for the Y86 two-port memory arbiter.
// Imported by y86_rr_pick and y86_mem_arbiter.
package y86_mem_pkg;

    // Deepest supported read latency and the data path width.
    localparam int RD_LAT_MAX = 4;
    localparam int DATA_W     = 32;

    // Wait counter holds RD_LAT-1, so it never needs more than RD_LAT_MAX-1.
    localparam int CNT_W      = 2;

    // Arbiter transaction FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Index of a requesting port: 0 = CPU, 1 = DMA/debug.
    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    // One-hot {port1, port0} vector for a port index.
    function automatic logic [1:0] port_onehot(input port_idx_t p);
        if (p == PORT1) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/y86_rr_pick.sv
// y86_rr_pick: combinational two-way arbitration picker.
// Default build: round-robin, the port that did not win last time wins a tie.
// With Y86_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie, last is ignored.
module y86_rr_pick
    import y86_mem_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    output port_idx_t  winner
);

`ifdef Y86_ARB_FIXED_PRIO_EN
    // Priority mode has no fairness state; keep the inputs visibly consumed.
    logic unused_pick_s;
    assign unused_pick_s = last ^ req[1];

    // Port 0 wins whenever it asks; otherwise port 1.
    always_comb begin
        if (req[0]) begin
            winner = PORT0;
        end else begin
            winner = PORT1;
        end
    end
`else
    // Single requester always wins; on a tie the port other than last wins.
    always_comb begin
        winner = PORT0;
        case (req)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11: begin
                if (last == PORT0) begin
                    winner = PORT1;
                end else begin
                    winner = PORT0;
                end
            end
            default: winner = PORT0;
        endcase
    end
`endif

endmodule

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: two-port arbiter in front of a single-ported memory.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE -> IDLE.
// All outputs are registered; they are decoded from the next state so that
// they line up exactly with the state they belong to.
// Optional build macro: Y86_ARB_FIXED_PRIO_EN (fixed priority, port 0 wins).
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [AW-1:0]     mem_A,
    output logic              mem_RE,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] mem_in
);

    // Value loaded into the wait counter when a read is issued.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    // FSM and latched transaction.
    arb_state_e          state_q, state_d;
    port_idx_t           port_q, port_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Registered outputs.
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_a_q, mem_a_d;
    logic [DATA_W-1:0]   mem_out_q, mem_out_d;

    // Arbitration.
    logic [1:0]          req_s;
    port_idx_t           winner_s;
    port_idx_t           last_s;

    assign req_s = {req1, req0};

    y86_rr_pick u_pick (
        .req    (req_s),
        .last   (last_s),
        .winner (winner_s)
    );

`ifdef Y86_ARB_FIXED_PRIO_EN
    // No fairness pointer in priority mode.
    assign last_s = PORT1;
`else
    port_idx_t last_q, last_d;

    // Remember which port won the most recent grant.
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && (|req_s)) begin
            last_d = winner_s;
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer; starts at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_s = last_q;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, transaction latch, wait counter and read-data capture.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|req_s) begin
                    port_d = winner_s;
                    if (winner_s == PORT1) begin
                        we_d    = we1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                    end else begin
                        we_d    = we0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    rdata_d = mem_in;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction latch, counter and read data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q  <= PORT0;
            we_q    <= 1'b0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            cnt_q   <= CNT_ZERO;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode from the next state so outputs are valid in that state.
    always_comb begin
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        mem_a_d   = {AW{1'b0}};
        mem_out_d = {DATA_W{1'b0}};
        if (state_d == IDLE) begin
            gnt_d = 2'b00;
        end else begin
            gnt_d = port_onehot(port_d);
        end
        if (state_d == DONE) begin
            done_d = port_onehot(port_d);
        end else begin
            done_d = 2'b00;
        end
        if (state_d == ISSUE) begin
            mem_a_d  = addr_d;
            mem_we_d = we_d;
            mem_re_d = ~we_d;
            if (we_d) begin
                mem_out_d = wdata_d;
            end else begin
                mem_out_d = {DATA_W{1'b0}};
            end
        end else begin
            mem_a_d   = {AW{1'b0}};
            mem_out_d = {DATA_W{1'b0}};
        end
    end

    // Output registers; reset drops every strobe and bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= {AW{1'b0}};
            mem_out_q <= {DATA_W{1'b0}};
        end else begin
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_out_q <= mem_out_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign rdata   = rdata_q;
    assign mem_A   = mem_a_q;
    assign mem_RE  = mem_re_q;
    assign mem_WE  = mem_we_q;
    assign mem_out = mem_out_q;

endmodule
